// File: rtl/drive_z_corr_pkg.sv
// drive_z_corr_pkg: shared pipeline depth, phase word type and modular word-sum helper
package drive_z_corr_pkg;
    localparam int Z_CORR_PIPE_DEPTH = 4;
    localparam int PHASE_W = 12;
    typedef logic [PHASE_W-1:0] phase_t;
    function automatic logic [63:0] sum_words(input logic [63:0] a, input logic [63:0] b, input int w);
        return (a + b) & ~({64{1'b1}} << w);
    endfunction
endpackage

// File: rtl/drive_z_corr_bank.sv
// drive_z_corr_bank: one bank's correction table, read-data register and env-fin/rz contribution mask
module drive_z_corr_bank #(
    parameter int DATA_WIDTH = 384,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  env_fin,
    input  logic                  rz_mode,
    input  logic [W-1:0]          phase_imm,
    output logic [DATA_WIDTH-1:0] contrib,
    output logic                  valid_s1,
    output logic                  rz_s1,
    output logic [W-1:0]          imm_s1
);
    logic [DATA_WIDTH-1:0] dout, rd_q;
    logic v0, env0, rz0, env1;
    logic [W-1:0] imm0;
    // wr_en arrives pre-qualified by wr_ready, so a write never collides with this bank's read
    sram_1rw0r0w_param_freepdk45 #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_DEPTH(DEPTH)
    ) u_sram (
        .clk0(clk),
        .csb0(~(wr_en | valid)),
        .web0(~wr_en),
        .addr0(wr_en ? wr_addr : rd_addr),
        .din0(wr_data),
        .dout0(dout)
    );
    always_ff @(posedge clk) begin
        env0 <= env_fin;
        rz0 <= rz_mode;
        imm0 <= phase_imm;
        env1 <= env0;
        rz_s1 <= rz0;
        imm_s1 <= imm0;
        rd_q <= dout;
        if (rst) {v0, valid_s1} <= '0;
        else {v0, valid_s1} <= {valid, v0};
    end
    assign contrib = (valid_s1 & ~env1 & ~rz_s1) ? rd_q : '0;
endmodule

// File: rtl/sram_1rw0r0w_param_freepdk45.sv
// sram_1rw0r0w_param_freepdk45: single-port synchronous RAM with active-low chip and write enables
module sram_1rw0r0w_param_freepdk45 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) mem[addr0] <= din0;
        else if (!csb0) dout0 <= mem[addr0];
    end
endmodule

// File: rtl/drive_z_corr_accum.sv
// drive_z_corr_accum: multi-bank Z-correction table sum accumulated into per-qubit virtual-frame phases
// DRIVE_Z_CORR_ACC_EN enables accumulation with frame_clr; otherwise each retired beat replaces the output
module drive_z_corr_accum
    import drive_z_corr_pkg::*;
#(
    parameter int NUM_BANK = 2,
    parameter int NUM_QUBIT_PER_BANK = 16,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
    parameter int Z_CORR_WIDTH = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          z_corr_memory_wr_en,
    input  logic [NUM_BANK-1:0]                           z_corr_memory_wr_sel,
    input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]          z_corr_memory_wr_addr,
    input  logic [Z_CORR_WIDTH*NUM_BANK*NUM_QUBIT_PER_BANK-1:0] z_corr_memory_wr_data,
    output logic                                          z_corr_memory_wr_ready,
    input  logic [NUM_BANK-1:0]                           valid_inst_list_in,
    input  logic [NUM_BANK*QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel,
    input  logic [NUM_BANK-1:0]                           is_read_env_fin,
    input  logic [NUM_BANK-1:0]                           rz_mode_in,
    input  logic [NUM_BANK*Z_CORR_WIDTH-1:0]              phase_imm_in,
    input  logic [NUM_BANK-1:0]                           frame_clr,
    output logic [Z_CORR_WIDTH*NUM_BANK*NUM_QUBIT_PER_BANK-1:0] z_corr_out,
    output logic [NUM_BANK-1:0]                           valid_z_corr_out,
    output logic [NUM_BANK-1:0]                           rz_mode_out
);
    localparam int W = Z_CORR_WIDTH;
    localparam int NQ = NUM_QUBIT_PER_BANK;
    localparam int TOTAL_QUBIT = NUM_BANK * NQ;
    localparam int DATA_WIDTH = W * TOTAL_QUBIT;
    localparam int NP = 1 << $clog2(NUM_BANK);
    logic [DATA_WIDTH-1:0] contrib [NUM_BANK];
    logic [W-1:0] imm1 [NUM_BANK];
    logic [NUM_BANK-1:0] v1, rz1, v2, rz2;
    logic [W-1:0] node [TOTAL_QUBIT][2*NP];
    logic [DATA_WIDTH-1:0] inc, inc_q;
    assign z_corr_memory_wr_ready = ~|(z_corr_memory_wr_sel & valid_inst_list_in);
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        drive_z_corr_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(QUBIT_ADDR_WIDTH_PER_BANK),
            .DEPTH(NQ),
            .W(W)
        ) u_bank (
            .clk(clk),
            .rst(rst),
            .wr_en(z_corr_memory_wr_en & z_corr_memory_wr_ready & z_corr_memory_wr_sel[b]),
            .wr_addr(z_corr_memory_wr_addr),
            .wr_data(z_corr_memory_wr_data),
            .valid(valid_inst_list_in[b]),
            .rd_addr(qubit_sel[b*QUBIT_ADDR_WIDTH_PER_BANK +: QUBIT_ADDR_WIDTH_PER_BANK]),
            .env_fin(is_read_env_fin[b]),
            .rz_mode(rz_mode_in[b]),
            .phase_imm(phase_imm_in[b*W +: W]),
            .contrib(contrib[b]),
            .valid_s1(v1[b]),
            .rz_s1(rz1[b]),
            .imm_s1(imm1[b])
        );
    end
    // Binary tree over leaves padded to a power of two; node[1] is the root
    always_comb begin
        inc = '0;
        for (int q = 0; q < TOTAL_QUBIT; q++) begin
            for (int n = 0; n < 2*NP; n++) node[q][n] = '0;
            for (int k = 0; k < NUM_BANK; k++) node[q][NP+k] = contrib[k][q*W +: W];
            for (int n = NP-1; n > 0; n--)
                node[q][n] = W'(sum_words(64'(node[q][2*n]), 64'(node[q][2*n+1]), W));
            inc[q*W +: W] = (v1[q/NQ] & rz1[q/NQ]) ? imm1[q/NQ] : node[q][1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q <= '0;
            v2 <= '0;
            rz2 <= '0;
            valid_z_corr_out <= '0;
            rz_mode_out <= '0;
            z_corr_out <= '0;
        end else begin
            inc_q <= inc;
            v2 <= v1;
            rz2 <= rz1 & v1;
            valid_z_corr_out <= v2;
            rz_mode_out <= rz2;
`ifdef DRIVE_Z_CORR_ACC_EN
            for (int q = 0; q < TOTAL_QUBIT; q++)
                z_corr_out[q*W +: W] <= (frame_clr[q/NQ] ? '0 : z_corr_out[q*W +: W]) + inc_q[q*W +: W];
`else
            if (|v2) z_corr_out <= inc_q;
`endif
        end
    end
`ifndef DRIVE_Z_CORR_ACC_EN
    logic unused_frame_clr;
    assign unused_frame_clr = ^frame_clr;
`endif
endmodule

// File: tb/tb_drive_z_corr_accum.sv
// tb_drive_z_corr_accum: directed and random beats against a cycle-level frame model with a latency queue
module tb_drive_z_corr_accum;
    import drive_z_corr_pkg::*;
    localparam int NB = 2;
    localparam int NQ = 16;
    localparam int W = 12;
    localparam int TQ = NB * NQ;
    localparam int DW = W * TQ;
    typedef struct packed {
        logic [DW-1:0] inc;
        logic [NB-1:0] v;
        logic [NB-1:0] rz;
    } beat_t;
    logic clk = 0;
    logic rst, wr_en, wr_ready;
    logic [NB-1:0] wr_sel, valid, env, rz, clr, v_out, rz_out;
    logic [3:0] wr_addr;
    logic [DW-1:0] wr_data, z_out;
    logic [NB*4-1:0] qsel;
    logic [NB*W-1:0] imm;
    logic [DW-1:0] tbl [NB][NQ];
    logic [DW-1:0] exp_z;
    logic [NB-1:0] exp_v, exp_rz;
    beat_t pipe [$];
    int n_tests = 0;
    int n_fail = 0;

    drive_z_corr_accum dut (
        .clk(clk),
        .rst(rst),
        .z_corr_memory_wr_en(wr_en),
        .z_corr_memory_wr_sel(wr_sel),
        .z_corr_memory_wr_addr(wr_addr),
        .z_corr_memory_wr_data(wr_data),
        .z_corr_memory_wr_ready(wr_ready),
        .valid_inst_list_in(valid),
        .qubit_sel(qsel),
        .is_read_env_fin(env),
        .rz_mode_in(rz),
        .phase_imm_in(imm),
        .frame_clr(clr),
        .z_corr_out(z_out),
        .valid_z_corr_out(v_out),
        .rz_mode_out(rz_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        valid = 0; qsel = 0; env = 0; rz = 0; imm = 0; clr = 0;
    endtask

    task automatic flush_pipe();
        pipe = {};
        repeat (Z_CORR_PIPE_DEPTH - 1) pipe.push_back('0);
    endtask

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: predict from current inputs, advance, then compare outputs
    task automatic cycle();
        beat_t cur, old;
        logic acc_ready;
        #1;
        acc_ready = ~|(wr_sel & valid);
        chk("wr_ready", wr_ready, acc_ready);
        cur.v = valid;
        cur.rz = rz & valid;
        for (int q = 0; q < TQ; q++) begin
            int b;
            int s;
            b = q / NQ;
            s = 0;
            if (valid[b] & rz[b]) s = int'(imm[b*W +: W]);
            else for (int k = 0; k < NB; k++)
                if (valid[k] & ~env[k] & ~rz[k]) s += int'(tbl[k][qsel[k*4 +: 4]][q*W +: W]);
            cur.inc[q*W +: W] = W'(s);
        end
        if (wr_en & acc_ready)
            for (int k = 0; k < NB; k++) if (wr_sel[k]) tbl[k][wr_addr] = wr_data;
        pipe.push_back(cur);
        old = pipe.pop_front();
`ifdef DRIVE_Z_CORR_ACC_EN
        for (int q = 0; q < TQ; q++)
            exp_z[q*W +: W] = (clr[q/NQ] ? 12'h000 : exp_z[q*W +: W]) + old.inc[q*W +: W];
`else
        if (|old.v) exp_z = old.inc;
`endif
        exp_v = old.v;
        exp_rz = old.rz;
        if (rst) begin
            exp_z = '0;
            exp_v = '0;
            exp_rz = '0;
            flush_pipe();
        end
        @(posedge clk);
        #1;
        chk("z_corr_out", z_out, exp_z);
        chk("valid_out", v_out, exp_v);
        chk("rz_out", rz_out, exp_rz);
    endtask

    initial begin
        exp_z = '0; exp_v = '0; exp_rz = '0;
        flush_pipe();
        idle();
        rst = 1;
        cycle();
        cycle();
        chk("reset_z", z_out, '0);
        chk("reset_v", v_out, '0);
        idle();
        for (int a = 0; a < NQ; a++) begin
            wr_en = 1; wr_sel = 2'b11; wr_addr = 4'(a); wr_data = rnd_vec();
            cycle();
        end
        wr_en = 1; wr_sel = 2'b01; wr_addr = 3; wr_data = {TQ{12'h010}}; cycle();
        wr_sel = 2'b10; wr_addr = 5; wr_data = {TQ{12'h005}}; cycle();
        wr_sel = 2'b01; wr_addr = 7; wr_data = {TQ{12'h020}}; cycle();
        wr_sel = 2'b01; wr_addr = 1; wr_data = {TQ{12'h001}}; cycle();
        wr_sel = 2'b10; wr_addr = 2; wr_data = {TQ{12'h002}}; cycle();
        idle();
        // cross-bank sum
        valid = 2'b11; qsel = {4'd5, 4'd3}; cycle(); idle();
        repeat (3) cycle();
        chk("sum_all", z_out, {TQ{12'h015}});
        chk("sum_valid", v_out, 2'b11);
        cycle();
        // wrap: bank0 frames to 0xFFE via Rz, then +0x005
        valid = 2'b01; rz = 2'b01; imm = {12'h000, 12'hFE9}; cycle(); idle();
        valid = 2'b10; qsel = {4'd5, 4'd0}; cycle(); idle();
        repeat (3) cycle();
`ifdef DRIVE_Z_CORR_ACC_EN
        chk("wrap_q0", 12'(z_out[11:0]), 12'h003);
        chk("wrap_q16", 12'(z_out[16*W +: W]), 12'h01A);
`else
        chk("wrap_q0", 12'(z_out[11:0]), 12'h005);
`endif
        // Rz beat on bank0 only
        valid = 2'b01; rz = 2'b01; imm = {12'h000, 12'h100}; cycle(); idle();
        repeat (3) cycle();
        chk("rz_out", rz_out, 2'b01);
`ifdef DRIVE_Z_CORR_ACC_EN
        chk("rz_q0", 12'(z_out[11:0]), 12'h103);
        chk("rz_q16", 12'(z_out[16*W +: W]), 12'h01A);
`else
        chk("rz_q0", 12'(z_out[11:0]), 12'h100);
`endif
        // env-fin masks bank1
        valid = 2'b11; env = 2'b10; qsel = {4'd2, 4'd1}; cycle(); idle();
        repeat (4) cycle();
        // write collision then retry
        wr_en = 1; wr_sel = 2'b01; wr_addr = 3; wr_data = {TQ{12'h777}}; valid = 2'b01; qsel = 0;
        #1 chk("coll_ready", wr_ready, 1'b0);
        cycle();
        valid = 0;
        #1 chk("retry_ready", wr_ready, 1'b1);
        cycle(); idle();
        valid = 2'b01; qsel = {4'd0, 4'd3}; cycle(); idle();
        repeat (4) cycle();
        // frame clear collides with +0x020
        valid = 2'b01; qsel = {4'd0, 4'd7}; cycle(); idle();
        cycle(); cycle();
        clr = 2'b01; cycle(); idle();
        chk("clr_q0", 12'(z_out[11:0]), 12'h020);
        cycle();
        // reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            valid = 2'b11; qsel = 8'($urandom); cycle();
        end
        idle(); rst = 1; cycle(); idle();
        chk("midrst_z", z_out, '0);
        chk("midrst_v", v_out, '0);
        repeat (5) cycle();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            valid = 2'($urandom);
            rz = 2'($urandom) & valid;
            env = 2'($urandom);
            qsel = 8'($urandom);
            imm = 24'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            wr_en = ($urandom_range(0, 3) == 0);
            wr_sel = 2'($urandom);
            wr_addr = 4'($urandom);
            wr_data = rnd_vec();
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        idle();
        repeat (5) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/drive_z_corr_accum.md
# drive_z_corr_accum

Parametrised successor of the drive-path Z-correction table for any number of banks. It stores per-bank correction vectors and sums the selected entries across banks through an adder tree. The summed increment, or a bank-wide Rz immediate, is accumulated modulo 2^Z_CORR_WIDTH into a per-qubit virtual-frame phase register. The block sits between the per-bank instruction-list decoders and the drive NCO phase inputs, and it replaces the earlier replace-only behaviour with persistent frame tracking.

## Interface
- NUM_BANK, 2: number of banks; any value ≥1.
- NUM_QUBIT_PER_BANK, 16: table depth per bank and qubits driven per bank.
- QUBIT_ADDR_WIDTH_PER_BANK, 4: table address width, equal to clog2(NUM_QUBIT_PER_BANK).
- Z_CORR_WIDTH, 12: phase word width W.
- Derived: TOTAL_QUBIT = NUM_BANK·NUM_QUBIT_PER_BANK; DATA_WIDTH = W·TOTAL_QUBIT.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- z_corr_memory_wr_en  in  1  table write request.
- z_corr_memory_wr_sel  in  NUM_BANK  one-hot or multi-hot bank select for the write.
- z_corr_memory_wr_addr  in  QUBIT_ADDR_WIDTH_PER_BANK  entry index.
- z_corr_memory_wr_data  in  DATA_WIDTH  correction vector, one W-bit word per qubit.
- z_corr_memory_wr_ready  out  1  write accepted this cycle.
- valid_inst_list_in  in  NUM_BANK  per-bank instruction valid.
- qubit_sel  in  NUM_BANK·QUBIT_ADDR_WIDTH_PER_BANK  per-bank read address.
- is_read_env_fin  in  NUM_BANK  masks that bank's table contribution to 0.
- rz_mode_in  in  NUM_BANK  the bank's instruction is a virtual Rz.
- phase_imm_in  in  NUM_BANK·W  per-bank Rz angle.
- frame_clr  in  NUM_BANK  zero the frame of that bank's qubits.
- z_corr_out  out  DATA_WIDTH  per-qubit accumulated phase.
- valid_z_corr_out  out  NUM_BANK  bank beat retired; pulses for 1 cycle.
- rz_mode_out  out  NUM_BANK  rz_mode delayed alongside valid_z_corr_out.

## Operation
- **Write handshake:**
  - z_corr_memory_wr_ready = ~|(z_corr_memory_wr_sel & valid_inst_list_in).
  - A write happens when wr_en & wr_ready; it updates every selected bank at wr_addr.
  - A write with wr_ready low is dropped. The writer holds its request and retries.
- **Read:** for each bank with valid_inst_list_in set, the entry at qubit_sel is read; data is registered one cycle later.
- **Bank contribution:** the registered data if valid & ~is_read_env_fin & ~rz_mode; otherwise 0.
- **Cross-bank sum:** per-qubit sum over all banks, computed modulo 2^W. Carries are discarded; an adder tree is used for any NUM_BANK.
- **Per-qubit increment for qubit q in bank b:**
  - phase_imm[b] if valid[b] & rz_mode[b];
  - otherwise the cross-bank sum.
- **Accumulate:** acc[q] ← (frame_clr[b] ? 0 : acc[q]) + inc[q], modulo 2^W.
  - Clear and add in the same cycle give acc = inc.
  - frame_clr is sampled in the accumulate stage (stage 3), not at input.
- **Idle cycles:** with no valid beat in flight, inc = 0 and the frames hold.

## Timing
- **Stages:**
  - S0: capture the inputs.
  - S1: table read data registered.
  - S2: mask and cross-bank sum registered.
  - S3: accumulate.
- **Latency:** valid_inst_list_in[b] at cycle N gives the updated z_corr_out and valid_z_corr_out[b]=1 at cycle N+4.
- **Throughput:** one beat per bank per cycle, fully pipelined.
- **Reset (any cycle, including mid-pipeline):**
  - z_corr_out = 0, valid_z_corr_out = 0, rz_mode_out = 0.
  - All stage valids are cleared; in-flight beats are lost.
  - Table contents are not reset.
- wr_ready is combinational from its inputs and does not depend on reset.

## Configuration
- DRIVE_Z_CORR_ACC_EN defined: accumulate behaviour as above; frame_clr is active.
- Not defined:
  - Legacy replace mode: z_corr_out[q] ← inc[q] on each cycle with any stage-3 valid, and holds otherwise.
  - frame_clr is ignored.
  - Latency is unchanged.

## Structure
- Package drive_z_corr_pkg holds:
  - Z_CORR_PIPE_DEPTH = 4;
  - the phase word typedef (parametrised by W via a localparam default of 12);
  - a sum-of-W-bit-words helper function used by the adder tree.
- One sub-module, drive_z_corr_bank, one instance per bank, containing:
  - the table, as sram_1rw0r0w_param_freepdk45;
  - the write/read address mux and csb/web generation;
  - the read-data register;
  - the env-fin/rz mask.
- The top level holds the adder tree, the accumulators, and the output pipeline.

## Test plan
All scenarios use the defaults: 2 banks, 16 qubits per bank, W=12.
- **Table read and cross-bank sum:** write bank0 entry 3 with all words 0x010 and bank1 entry 5 with all words 0x005; then valid=2'b11, qubit_sel={5,3} -> at N+4 all 32 words = 0x015 and valid_z_corr_out=2'b11.
- **Wrap-around:** set acc = 0xFFE, then apply an increment of 0x005 -> acc = 0x003.
- **Rz beat:** rz_mode=2'b01, phase_imm bank0 = 0x100, valid=2'b01 -> qubits 0–15 increase by 0x100, qubits 16–31 unchanged, rz_mode_out=2'b01 at N+4.
- **Env-fin mask:** is_read_env_fin=2'b10 with both banks valid -> only bank0's entry is added.
- **Write collision:** wr_en with wr_sel=2'b01 in the same cycle as valid=2'b01 -> wr_ready=0 and the table is unchanged; repeated next cycle with valid=0 -> accepted.
- **Reset and frame clear:**
  - Clear collides with an increment of 0x020 -> acc = 0x020.
  - rst asserted while 3 beats are in flight -> outputs 0 next cycle and no later valid pulses.
